// File: rtl/decode_imm_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package decode_imm_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    // Decoded fields carried across the ID/EX boundary (PC kept separately).
    typedef struct packed {
        logic [31:0] immext;
        logic [2:0]  immsrc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  opcode;
    } id_fields_t;

endpackage

// File: rtl/decode_imm_stage_extend.sv
// Immediate extension unit: builds the sign-extended immediate for a given format.
// Latency: combinational.
// Backpressure: none.
module extend
    import decode_imm_stage_pkg::*;
(
    input  logic [31:7] i_instr,
    input  logic [2:0]  i_immsrc,
    output logic [31:0] o_immext
);

    // Reassemble immediate bits per RV32I format
    always_comb begin
        o_immext = '0;
        case (i_immsrc)
            IMM_I: o_immext = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: o_immext = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_immext = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_J: o_immext = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            IMM_U: o_immext = {i_instr[31:12], 12'b0};
            default: o_immext = '0;
        endcase
    end

endmodule

// File: rtl/decode_imm_stage_imm_sel.sv
// Opcode classifier: selects the immediate format and flags unknown opcodes.
// Latency: combinational.
// Backpressure: none, pure function of the opcode.
module imm_sel_decode
    import decode_imm_stage_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [2:0] o_immsrc,
    output logic       o_illegal
);

    // Opcode -> immediate format; R-type, FENCE and SYSTEM default to I (immext unused)
    always_comb begin
        o_immsrc  = IMM_I;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: o_immsrc = IMM_I;
            OPC_STORE:                      o_immsrc = IMM_S;
            OPC_BRANCH:                     o_immsrc = IMM_B;
            OPC_JAL:                        o_immsrc = IMM_J;
            OPC_LUI, OPC_AUIPC:             o_immsrc = IMM_U;
            OPC_OP, OPC_FENCE, OPC_SYSTEM:  o_immsrc = IMM_I;
            default:                        o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode stage: classifies opcodes, extends immediates, registers ID/EX fields, traps illegal opcodes.
// Latency: 1 cycle from accept to d_valid.
// Backpressure: in_ready drops while the ID/EX register is full and not consumed, in TRAP, or on flush.
module decode_imm_stage
    import decode_imm_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_instr,
    input  logic [XLEN-1:0] i_in_pc,
    input  logic            i_flush,
    output logic            o_d_valid,
    input  logic            i_d_ready,
    output logic [XLEN-1:0] o_d_pc,
    output logic [31:0]     o_d_immext,
    output logic [2:0]      o_d_immsrc,
    output logic [4:0]      o_d_rd,
    output logic [4:0]      o_d_rs1,
    output logic [4:0]      o_d_rs2,
    output logic [2:0]      o_d_funct3,
    output logic [6:0]      o_d_opcode,
    output logic            o_illegal,
    output logic [31:0]     o_trap_instr,
    output logic [XLEN-1:0] o_trap_pc,
    input  logic            i_trap_ack
);

    logic [2:0]      w_immsrc;
    logic            w_illegal_opc;
    logic [31:0]     w_immext;
    logic            w_accept;
    logic            w_accept_legal;
    logic            w_accept_illegal;

    state_e          r_state;
    logic            r_illegal;
    logic            r_d_valid;
    logic [31:0]     r_trap_instr;
    logic [XLEN-1:0] r_trap_pc;
    logic [XLEN-1:0] r_d_pc;
    id_fields_t      r_d;

    imm_sel_decode u_imm_sel (
        .i_opcode  (i_in_instr[6:0]),
        .o_immsrc  (w_immsrc),
        .o_illegal (w_illegal_opc)
    );

    extend u_extend (
        .i_instr  (i_in_instr[31:7]),
        .i_immsrc (w_immsrc),
        .o_immext (w_immext)
    );

    // Ready only in RUN, never on a flush cycle, and only when the ID/EX slot frees up this edge
    assign o_in_ready       = !i_reset && (r_state == ST_RUN) && !i_flush && (!r_d_valid || i_d_ready);
    assign w_accept         = i_in_valid && o_in_ready;
    assign w_accept_legal   = w_accept && !w_illegal_opc;
    assign w_accept_illegal = w_accept && w_illegal_opc;

    // Control: FSM, ID/EX valid bit and trap capture; flush overrides everything else
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_RUN;
            r_illegal    <= 1'b0;
            r_d_valid    <= 1'b0;
            r_trap_instr <= '0;
            r_trap_pc    <= RESET_PC;
        end else if (i_flush) begin
            r_state   <= ST_RUN;
            r_illegal <= 1'b0;
            r_d_valid <= 1'b0;
        end else begin
            if (w_accept_legal) begin
                r_d_valid <= 1'b1;
            end else if (i_d_ready) begin
                r_d_valid <= 1'b0;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_accept_illegal) begin
                        r_state      <= ST_TRAP;
                        r_illegal    <= 1'b1;
                        r_trap_instr <= i_in_instr;
                        r_trap_pc    <= i_in_pc;
                    end
                end
                ST_TRAP: begin
                    if (i_trap_ack) begin
                        r_state   <= ST_RUN;
                        r_illegal <= 1'b0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // ID/EX data: loaded only on a legal accept, otherwise held (stall-stable)
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_d_pc <= RESET_PC;
            r_d    <= '0;
        end else if (w_accept_legal) begin
            r_d_pc     <= i_in_pc;
            r_d.immext <= w_immext;
            r_d.immsrc <= w_immsrc;
            r_d.rd     <= i_in_instr[11:7];
            r_d.rs1    <= i_in_instr[19:15];
            r_d.rs2    <= i_in_instr[24:20];
            r_d.funct3 <= i_in_instr[14:12];
            r_d.opcode <= i_in_instr[6:0];
        end
    end

    assign o_d_valid    = r_d_valid;
    assign o_d_pc       = r_d_pc;
    assign o_d_immext   = r_d.immext;
    assign o_d_immsrc   = r_d.immsrc;
    assign o_d_rd       = r_d.rd;
    assign o_d_rs1      = r_d.rs1;
    assign o_d_rs2      = r_d.rs2;
    assign o_d_funct3   = r_d.funct3;
    assign o_d_opcode   = r_d.opcode;
    assign o_illegal    = r_illegal;
    assign o_trap_instr = r_trap_instr;
    assign o_trap_pc    = r_trap_pc;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed bench for decode_imm_stage: reset, formats, stall, trap, flush.
// Latency: inputs driven on negedge, registered outputs sampled 1 time unit after posedge.
// Backpressure: exercised via d_ready and trap/flush scenarios.
module tb_decode_imm_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_immext;
    logic [2:0]  d_immsrc;
    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [2:0]  d_funct3;
    logic [6:0]  d_opcode;
    logic        illegal;
    logic [31:0] trap_instr;
    logic [31:0] trap_pc;
    logic        trap_ack;

    int checks = 0;
    int errors = 0;

    logic [31:0] f_instr [5] = '{32'hFFF00093, 32'hFE20AE23, 32'h00000463, 32'h123452B7, 32'h0080006F};
    logic [2:0]  f_src   [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011};
    logic [31:0] f_imm   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'h00000008};
    logic [6:0]  f_opc   [5] = '{7'h13, 7'h23, 7'h63, 7'h37, 7'h6F};

    decode_imm_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_instr   (in_instr),
        .i_in_pc      (in_pc),
        .i_flush      (flush),
        .o_d_valid    (d_valid),
        .i_d_ready    (d_ready),
        .o_d_pc       (d_pc),
        .o_d_immext   (d_immext),
        .o_d_immsrc   (d_immsrc),
        .o_d_rd       (d_rd),
        .o_d_rs1      (d_rs1),
        .o_d_rs2      (d_rs2),
        .o_d_funct3   (d_funct3),
        .o_d_opcode   (d_opcode),
        .o_illegal    (illegal),
        .o_trap_instr (trap_instr),
        .o_trap_pc    (trap_pc),
        .i_trap_ack   (trap_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; d_ready = 1'b0; trap_ack = 1'b0;
        #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid got %0b exp 0", d_valid); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %0b exp 0", illegal); end
        checks++; if (d_pc !== RST_PC) begin errors++; $display("FAIL rst_d_pc got %h exp %h", d_pc, RST_PC); end
        checks++; if (trap_pc !== RST_PC) begin errors++; $display("FAIL rst_trap_pc got %h exp %h", trap_pc, RST_PC); end
        checks++; if (d_immext !== 32'h0) begin errors++; $display("FAIL rst_d_immext got %h exp 0", d_immext); end
        checks++; if (trap_instr !== 32'h0) begin errors++; $display("FAIL rst_trap_instr got %h exp 0", trap_instr); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_formats();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = f_instr[i]; in_pc = 32'h1000 + 32'(4 * i); d_ready = 1'b1;
            @(posedge clk); #1;
            checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid got %0b exp 1", i, d_valid); end
            checks++; if (d_immsrc !== f_src[i]) begin errors++; $display("FAIL fmt%0d_immsrc got %b exp %b", i, d_immsrc, f_src[i]); end
            checks++; if (d_immext !== f_imm[i]) begin errors++; $display("FAIL fmt%0d_immext got %h exp %h", i, d_immext, f_imm[i]); end
            checks++; if (d_pc !== 32'h1000 + 32'(4 * i)) begin errors++; $display("FAIL fmt%0d_pc got %h exp %h", i, d_pc, 32'h1000 + 32'(4 * i)); end
            checks++; if (d_opcode !== f_opc[i]) begin errors++; $display("FAIL fmt%0d_opcode got %h exp %h", i, d_opcode, f_opc[i]); end
            if (i == 1) begin
                // sw x2, -4(x1)
                checks++; if ({d_rd, d_rs1, d_rs2, d_funct3} !== {5'd28, 5'd1, 5'd2, 3'd2}) begin
                    errors++; $display("FAIL fmt_s_fields got rd=%0d rs1=%0d rs2=%0d f3=%0d exp 28 1 2 2", d_rd, d_rs1, d_rs2, d_funct3);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL fmt_drain got %0b exp 0", d_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h2000; d_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (d_valid !== 1'b1 || d_immext !== 32'd5) begin errors++; $display("FAIL bp_load got v=%0b imm=%h exp 1 5", d_valid, d_immext); end
        @(negedge clk);
        in_instr = 32'h00700193; in_pc = 32'h2004;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b exp 0", c, in_ready); end
            checks++; if ({d_valid, d_immext, d_rd, d_pc} !== {1'b1, 32'd5, 5'd2, 32'h2000}) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%0b imm=%h rd=%0d pc=%h exp 1 5 2 2000", c, d_valid, d_immext, d_rd, d_pc);
            end
        end
        @(negedge clk);
        d_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", in_ready); end
        @(posedge clk); #1;
        checks++; if ({d_valid, d_immext, d_rd, d_pc} !== {1'b1, 32'd7, 5'd3, 32'h2004}) begin
            errors++; $display("FAIL bp_b2b got v=%0b imm=%h rd=%0d pc=%h exp 1 7 3 2004", d_valid, d_immext, d_rd, d_pc);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", d_valid); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h40; d_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL ill_d_valid got %0b exp 0", d_valid); end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %0b exp 1", illegal); end
        checks++; if (trap_instr !== 32'h7F) begin errors++; $display("FAIL ill_trap_instr got %h exp 7f", trap_instr); end
        checks++; if (trap_pc !== 32'h40) begin errors++; $display("FAIL ill_trap_pc got %h exp 40", trap_pc); end
        @(negedge clk);
        in_instr = 32'h00500113; in_pc = 32'h44;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL ill_hold[%0d] got rdy=%0b v=%0b exp 0 0", c, in_ready, d_valid); end
            @(negedge clk);
        end
        in_valid = 1'b0; trap_ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (illegal !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ill_ack got ill=%0b rdy=%0b exp 0 1", illegal, in_ready); end
        @(negedge clk);
        trap_ack = 1'b0;
        #1;
        checks++; if (trap_instr !== 32'h7F || trap_pc !== 32'h40) begin errors++; $display("FAIL ill_trap_hold got %h %h exp 7f 40", trap_instr, trap_pc); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h3000; d_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL fl_load got %0b exp 1", d_valid); end
        @(negedge clk);
        flush = 1'b1; in_instr = 32'h00900213; in_pc = 32'h3004;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready got %0b exp 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL fl_d_valid got %0b exp 0", d_valid); end
        checks++; if (d_immext !== 32'd5 || d_pc !== 32'h3000) begin errors++; $display("FAIL fl_not_loaded got imm=%h pc=%h exp 5 3000", d_immext, d_pc); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_flush_trap();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h84; d_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (illegal !== 1'b1 || trap_pc !== 32'h84) begin errors++; $display("FAIL ft_enter got ill=%0b pc=%h exp 1 84", illegal, trap_pc); end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ft_exit got %0b exp 0", illegal); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ft_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h200; d_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL rm_load got %0b exp 1", d_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (d_valid !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rm_clear got v=%0b ill=%0b exp 0 0", d_valid, illegal); end
        checks++; if (d_pc !== RST_PC) begin errors++; $display("FAIL rm_d_pc got %h exp %h", d_pc, RST_PC); end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %0b exp 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_illegal();
        test_flush();
        test_flush_trap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
